// File: rtl/alu_exerciser.sv
// Self-test sequencer: sweeps LFSR operands through all eight ALU funcs and counts masked mismatches.
// Define ALU_EXERCISER_LOG_EN to add the first_fail capture port.
module alu_exerciser #(
  parameter int SETTLE_CYC   = 2,
  parameter int OPS_PER_FUNC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] res_bus,
  output logic [15:0] op_bus,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_cnt,
  output logic        pass
`ifdef ALU_EXERCISER_LOG_EN
  ,
  output logic [15:0] first_fail
`endif
);

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, FIN} state_t;

  state_t      r_state, w_stateNext;
  logic [3:0]  r_waitCnt;
  logic [7:0]  r_opIdx;
  logic [2:0]  r_func;
  logic [7:0]  r_lfsr;
  logic [15:0] r_op;
  logic [7:0]  r_errCnt;
  logic        r_pass;
  logic        r_done;
`ifdef ALU_EXERCISER_LOG_EN
  logic [15:0] r_firstFail;
`endif

  logic [7:0]  w_lfsrStep;
  logic        w_lastInFunc;
  logic        w_lastOp;
  logic [2:0]  w_funcNext;
  logic [3:0]  w_a, w_b;
  logic [4:0]  w_addSum, w_subSum;
  logic        w_addOvf, w_subOvf;
  logic [15:0] w_expect, w_mask;
  logic        w_mismatch;

  assign w_lfsrStep   = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_lastInFunc = (r_opIdx == 8'(OPS_PER_FUNC - 1));
  assign w_lastOp     = w_lastInFunc && (r_func == 3'd7);
  assign w_funcNext   = w_lastInFunc ? r_func + 3'd1 : r_func;

  assign w_a      = r_op[3:0];
  assign w_b      = r_op[7:4];
  assign w_addSum = {1'b0, w_a} + {1'b0, w_b};
  assign w_subSum = {1'b0, w_a} + {1'b0, ~w_b} + 5'd1;
  assign w_addOvf = (w_a[3] == w_b[3]) && (w_addSum[3] != w_a[3]);
  assign w_subOvf = (w_a[3] != w_b[3]) && (w_subSum[3] != w_a[3]);

  // Reference ALU result in LED format; the mask selects only the fields meaningful for the func.
  always_comb begin
    w_expect = 16'h0000;
    w_mask   = 16'h0000;
    case (r_func)
      3'd0: begin w_expect[5:0] = {w_addOvf, w_addSum}; w_mask = 16'h003F; end
      3'd1: begin w_expect[5:0] = {w_subOvf, w_subSum}; w_mask = 16'h003F; end
      3'd2: begin w_expect[9:6] = ~w_a;        w_mask = 16'h03C0; end
      3'd3: begin w_expect[9:6] = w_a & w_b;   w_mask = 16'h03C0; end
      3'd4: begin w_expect[9:6] = w_a | w_b;   w_mask = 16'h03C0; end
      3'd5: begin w_expect[9:6] = w_a ^ w_b;   w_mask = 16'h03C0; end
      3'd6: begin w_expect[6] = $signed(w_a) < $signed(w_b); w_mask = 16'h0040; end
      default: begin w_expect[6] = (w_a == w_b); w_mask = 16'h0040; end
    endcase
  end

  assign w_mismatch = |((res_bus ^ w_expect) & w_mask);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    case (r_state)
      IDLE:  if (start) w_stateNext = DRIVE;
      DRIVE: begin busy = 1'b1; w_stateNext = WAIT; end
      WAIT: begin
        busy = 1'b1;
        if (r_waitCnt == 4'(SETTLE_CYC - 1)) w_stateNext = CHECK;
      end
      CHECK: begin
        busy        = 1'b1;
        w_stateNext = w_lastOp ? FIN : DRIVE;
      end
      FIN:     w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // op_bus is only reloaded on the edge that enters DRIVE, so it holds through WAIT/CHECK and after FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= 16'h0000;
      r_lfsr    <= 8'hA5;
      r_func    <= 3'd0;
      r_opIdx   <= 8'd0;
      r_waitCnt <= 4'd0;
      r_errCnt  <= 8'd0;
      r_pass    <= 1'b0;
      r_done    <= 1'b0;
`ifdef ALU_EXERCISER_LOG_EN
      r_firstFail <= 16'h0000;
`endif
    end else begin
      r_done <= (r_state == FIN);
      case (r_state)
        IDLE: if (start) begin
          r_lfsr   <= 8'hA5;
          r_func   <= 3'd0;
          r_opIdx  <= 8'd0;
          r_op     <= 16'h00A5;
          r_errCnt <= 8'd0;
          r_pass   <= 1'b0;
`ifdef ALU_EXERCISER_LOG_EN
          r_firstFail <= 16'h0000;
`endif
        end
        DRIVE: r_waitCnt <= 4'd0;
        WAIT:  r_waitCnt <= r_waitCnt + 4'd1;
        CHECK: begin
          r_lfsr <= w_lfsrStep;
          if (w_mismatch && (r_errCnt != 8'hFF)) r_errCnt <= r_errCnt + 8'd1;
`ifdef ALU_EXERCISER_LOG_EN
          if (w_mismatch && (r_errCnt == 8'd0)) r_firstFail <= r_op;
`endif
          if (!w_lastOp) begin
            r_op    <= {5'b00000, w_funcNext, w_lfsrStep};
            r_func  <= w_funcNext;
            r_opIdx <= w_lastInFunc ? 8'd0 : r_opIdx + 8'd1;
          end
        end
        FIN:     r_pass <= (r_errCnt == 8'd0);
        default: ;
      endcase
    end
  end

  assign op_bus  = r_op;
  assign done    = r_done;
  assign err_cnt = r_errCnt;
  assign pass    = r_pass;
`ifdef ALU_EXERCISER_LOG_EN
  assign first_fail = r_firstFail;
`endif

endmodule

// File: tb/tb_alu_exerciser.sv
// Testbench for alu_exerciser: an integer-arithmetic ALU answers op_bus, with optional fault injection,
// and sweep results are predicted from the LFSR sequence and per-func compare rules.
module tb_alu_exerciser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start16 = 1'b0, start64 = 1'b0;
  logic [15:0] op16, op64, res16, res64;
  logic        busy16, busy64, done16, done64, pass16, pass64;
  logic [7:0]  err16, err64;
  int          mode16 = 0, mode64 = 0;
  int          nTests = 0, nFail = 0;
`ifdef ALU_EXERCISER_LOG_EN
  logic [15:0] ff16, ff64;
`endif

  always #5 clk = ~clk;

  alu_exerciser #(.SETTLE_CYC(2), .OPS_PER_FUNC(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .res_bus(res16), .op_bus(op16),
    .busy(busy16), .done(done16), .err_cnt(err16), .pass(pass16)
`ifdef ALU_EXERCISER_LOG_EN
    , .first_fail(ff16)
`endif
  );

  alu_exerciser #(.SETTLE_CYC(2), .OPS_PER_FUNC(64)) u_dut64 (
    .clk(clk), .rst(rst), .start(start64), .res_bus(res64), .op_bus(op64),
    .busy(busy64), .done(done64), .err_cnt(err64), .pass(pass64)
`ifdef ALU_EXERCISER_LOG_EN
    , .first_fail(ff64)
`endif
  );

  // Behavioural ALU: mode 1 flips logic[0] for func 7, mode 2 flips it for every func.
  function automatic logic [15:0] respond(input logic [15:0] op, input int mode);
    int a, b, sa, sb, f, s, d, ovf, lg, r;
    a  = int'(op[3:0]);
    b  = int'(op[7:4]);
    f  = int'(op[10:8]);
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    if (f == 1) begin s = a + (15 - b) + 1; d = sa - sb; end
    else        begin s = a + b;            d = sa + sb; end
    ovf = (d > 7 || d < -8) ? 1 : 0;
    case (f)
      2: lg = 15 - a;
      3: lg = a & b;
      4: lg = a | b;
      5: lg = a ^ b;
      6: lg = (sa < sb) ? 1 : 0;
      7: lg = (a == b) ? 1 : 0;
      default: lg = 0;
    endcase
    r = lg * 64 + ovf * 32 + (s / 16) * 16 + (s % 16);
    if (mode == 2 || (mode == 1 && f == 7)) r = r ^ 64;
    return 16'(r);
  endfunction

  assign res16 = respond(op16, mode16);
  assign res64 = respond(op64, mode64);

  function automatic int lfsrNext(input int x);
    int fb;
    fb = ((x >> 7) + (x >> 5) + (x >> 4) + (x >> 3)) % 2;
    return (x * 2 + fb) % 256;
  endfunction

  function automatic int fieldMask(input int f);
    if (f <= 1) return 'h3F;
    if (f <= 5) return 'h3C0;
    return 'h40;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit sel);
    if (sel) start64 = 1'b1; else start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    start64 = 1'b0;
  endtask

  // One sweep on the chosen instance; abortAt > 0 pulses rst at that cycle instead of finishing.
  task automatic runSweep(input bit sel, input int mode, input int abortAt, input bit spur);
    int ops, nOps, total, x, cnt, expErr, firstFail, spurC, c;
    int expOp[$];
    bit finished;
    ops   = sel ? 64 : 16;
    nOps  = 8 * ops;
    total = nOps * 4 + 1;
    x = 'hA5; cnt = 0; firstFail = 0;
    for (int k = 0; k < nOps; k++) begin
      int f, flip;
      f    = k / ops;
      flip = (mode == 2 || (mode == 1 && f == 7)) ? 'h40 : 0;
      expOp.push_back(f * 256 + x);
      if ((flip & fieldMask(f)) != 0) begin
        if (cnt == 0) firstFail = f * 256 + x;
        cnt++;
      end
      x = lfsrNext(x);
    end
    expErr = (cnt > 255) ? 255 : cnt;
    if (sel) mode64 = mode; else mode16 = mode;
    spurC = 20 + $urandom_range(0, 400);
    repeat ($urandom_range(0, 5)) @(posedge clk);
    #1;
    applyStimulus(sel);
    c = 0;
    finished = 0;
    while (!finished) begin
      if (c % 4 == 0 && c / 4 < nOps) begin
        checkOutput("opBus", sel ? op64 : op16, expOp[c / 4]);
        checkOutput("busyDuringOp", sel ? busy64 : busy16, 1);
      end
      if (abortAt > 0 && c == abortAt) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abortBusy", busy16, 0);
        checkOutput("abortOpBus", op16, 0);
        checkOutput("abortErrCnt", err16, 0);
        checkOutput("abortDone", done16, 0);
        checkOutput("abortPass", pass16, 0);
        finished = 1;
      end else if ((sel ? done64 : done16) === 1'b1) begin
        checkOutput("doneTiming", c, total);
        checkOutput("errCnt", sel ? err64 : err16, expErr);
        checkOutput("pass", sel ? pass64 : pass16, (expErr == 0) ? 1 : 0);
        checkOutput("busyAtDone", sel ? busy64 : busy16, 0);
`ifdef ALU_EXERCISER_LOG_EN
        checkOutput("firstFail", sel ? ff64 : ff16, firstFail);
`endif
        @(posedge clk); #1;
        checkOutput("donePulseWidth", sel ? done64 : done16, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("opBusHeld", sel ? op64 : op16, expOp[nOps - 1]);
        checkOutput("passHeld", sel ? pass64 : pass16, (expErr == 0) ? 1 : 0);
        finished = 1;
      end else if (c > total + 20) begin
        checkOutput("doneTimeout", c, total);
        finished = 1;
      end else begin
        if (spur && (c == 10 || c == 300 || c == spurC)) begin
          if (sel) start64 = 1'b1; else start16 = 1'b1;
        end else begin
          start16 = 1'b0;
          start64 = 1'b0;
        end
        @(posedge clk); #1;
        c++;
      end
    end
    start16 = 1'b0;
    start64 = 1'b0;
  endtask

  initial begin
    // Reset also wins over a simultaneous start.
    rst = 1'b1;
    start16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstOpBus", op16, 16'h0000);
    checkOutput("rstBusy", busy16, 0);
    checkOutput("rstDone", done16, 0);
    checkOutput("rstErrCnt", err16, 0);
    checkOutput("rstPass", pass16, 0);
    start16 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idleBusy", busy16, 0);

    runSweep(1'b0, 0, 0, 1'b1);
    runSweep(1'b0, 1, 0, 1'b1);
    runSweep(1'b0, 2, 150 + $urandom_range(0, 100), 1'b0);
    runSweep(1'b0, 2, 0, 1'b0);
    runSweep(1'b0, 0, 0, 1'b0);
    runSweep(1'b1, 2, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/alu_exerciser.md
ALU_EXERCISER -- requirements
Module: alu_exerciser

Interface
REQ-001 Parameter SETTLE_CYC, default 2, sets the wait cycles between driving an op and sampling its result; legal range 1..15.
REQ-002 Parameter OPS_PER_FUNC, default 16, sets the number of operand pairs issued per func code; legal range 1..256.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  level sampled in IDLE; begins one sweep.
REQ-006 op_bus  output  16  switch-format command: [15:11]=0, [10:8]=func, [7:4]=b, [3:0]=a.
REQ-007 res_bus  input  16  LED-format result: [15:10]=0, [9:6]=logic, [5]=overflow, [4]=cout, [3:0]=sum.
REQ-008 busy  output  1  high from DRIVE through CHECK of the last op.
REQ-009 done  output  1  one-cycle pulse at the end of a sweep.
REQ-010 err_cnt  output  8  mismatch count, saturating at 255.
REQ-011 pass  output  1  registered (err_cnt==0) at done, held until the next start.

Function
REQ-012 FSM states SHALL be IDLE, DRIVE, WAIT, CHECK and FIN; IDLE->DRIVE when start=1, DRIVE->WAIT, WAIT->CHECK after SETTLE_CYC cycles, CHECK->DRIVE if ops remain, else CHECK->FIN, FIN->IDLE.
REQ-013 Each op SHALL take exactly SETTLE_CYC+2 cycles; op_bus SHALL update only on entry to DRIVE and hold through WAIT and CHECK.
REQ-014 Operands SHALL come from an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, with {b,a}=lfsr; the LFSR reseeds to 8'hA5 on start and advances once per CHECK.
REQ-015 func SHALL start at 3'b000 and increment after every OPS_PER_FUNC ops, giving 8*OPS_PER_FUNC ops per sweep in func order 000..111.
REQ-016 res_bus SHALL be sampled in CHECK and compared against an internal model under a per-func mask; mismatch increments err_cnt.
REQ-017 Func 000: expected {cout,sum}=a+b and overflow=signed add overflow; compare only sum, cout and overflow.
REQ-018 Func 001: expected {cout,sum}=a+~b+1 and overflow=signed sub overflow; compare only sum, cout and overflow.
REQ-019 Funcs 010/011/100/101: expected logic = ~a, a&b, a|b, a^b respectively; compare only logic[3:0].
REQ-020 Func 110: expected logic[0]=(signed a < signed b); func 111: expected logic[0]=(a==b); compare only logic[0].
REQ-021 start SHALL be ignored while not in IDLE; err_cnt clears and pass deasserts on an accepted start.
REQ-022 err_cnt at 255 SHALL hold at 255 on further mismatches.
REQ-023 After FIN, op_bus SHALL hold the last issued op until the next DRIVE.

Reset
REQ-024 rst=1 SHALL force IDLE, op_bus=16'h0000, busy=0, done=0, err_cnt=0, pass=0 and lfsr=8'hA5 on the next edge, including mid-sweep; a reset overrides start in the same cycle.

Configuration
REQ-025 When ALU_EXERCISER_LOG_EN is defined, an output first_fail[15:0] SHALL exist; it captures op_bus at the first mismatch of a sweep, is 0 at reset/start, and is not overwritten by later mismatches.
REQ-026 When ALU_EXERCISER_LOG_EN is undefined, the first_fail port and its register SHALL be absent; all other behaviour is identical.

Verification
REQ-027 Defaults, golden ALU model on res_bus, start pulse -> first DRIVE op_bus=16'h00A5, done exactly 513 cycles after start sampled, err_cnt=0, pass=1.
REQ-028 Golden model with logic[0] inverted for func 111 only -> err_cnt=16, pass=0; with LOG_EN, first_fail[10:8]=3'b111.
REQ-029 OPS_PER_FUNC=64, logic[0] inverted for all funcs -> 384 raw mismatches, err_cnt saturates at 255.
REQ-030 start re-asserted at cycles 10 and 300 of a sweep -> ignored, done timing unchanged (513).
REQ-031 rst asserted at cycle 100 of a sweep -> next cycle busy=0, op_bus=0, err_cnt=0; a new start reproduces the identical op_bus sequence starting at 16'h00A5.
